// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the game front end and the tick scheduler.
// master drives the player/switch inputs; slave is the scheduler.
interface game_tick_scheduler_if;
    logic       start;
    logic       pause;
    logic       auto_mode;
    logic [6:0] speed_sw;
    logic       hit;
    logic       miss;
    logic       tick;
    logic [2:0] level;
    logic [3:0] misses;
    logic [1:0] state;
    logic [4:0] exp_out;

    modport master (
        output start, pause, auto_mode, speed_sw, hit, miss,
        input  tick, level, misses, state, exp_out
    );

    modport slave (
        input  start, pause, auto_mode, speed_sw, hit, miss,
        output tick, level, misses, state, exp_out
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game-tick generator: programmable power-of-two period, manual/auto speed,
// and run/pause/game-over sequencing for the arrow-scroll datapath.
module game_tick_scheduler #(
    parameter int CNT_W          = 26,
    parameter int EXP_MIN        = 19,
    parameter int EXP_DEFAULT    = 22,
    parameter int HITS_PER_LEVEL = 8,
    parameter int MAX_LEVEL      = 6,
    parameter int MAX_MISSES     = 10
) (
    input logic                  clk,
    input logic                  reset,
    game_tick_scheduler_if.slave bus
);
    localparam int HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        OVER   = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, last_c;
    logic [HC_W-1:0]   hits_q, hits_d;
    logic [2:0]        level_q, level_d;
    logic [3:0]        misses_q, misses_d;
    logic              tick_q, tick_d;
    logic [4:0]        exp_c, exp_q;
    logic              game_over_c;

    // Exponent follows the inputs this cycle, so a speed change takes effect
    // on the very next compare rather than one cycle later.
    always_comb begin
        exp_c = 5'(EXP_DEFAULT);
        if (bus.auto_mode) begin
            exp_c = 5'(EXP_MIN + 6) - {2'b00, level_q};
        end else begin
            for (int i = 0; i < 7; i++)
                if (bus.speed_sw[i]) exp_c = 5'(EXP_MIN + 6 - i);
        end
        last_c = (CNT_W'(1) << exp_c) - CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hits_d      = hits_q;
        level_d     = level_q;
        misses_d    = misses_q;
        tick_d      = 1'b0;
        game_over_c = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    hits_d   = '0;
                    level_d  = '0;
                    misses_d = '0;
                end
            end
            RUN: begin
                if (bus.hit) begin
                    if (hits_q == HC_W'(HITS_PER_LEVEL - 1)) begin
                        hits_d = '0;
                        if (bus.auto_mode && level_q < 3'(MAX_LEVEL))
                            level_d = level_q + 3'd1;
                    end else begin
                        hits_d = hits_q + HC_W'(1);
                    end
                end
                if (bus.miss) begin
                    misses_d    = misses_q + 4'd1;
                    game_over_c = (misses_q == 4'(MAX_MISSES - 1));
                end
                // Game over wins over both pause and a tick due this edge.
                if (game_over_c) begin
                    state_d = OVER;
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end else if (cnt_q >= last_c) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAUSED: begin
                if (!bus.pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hits_q   <= '0;
            level_q  <= '0;
            misses_q <= '0;
            tick_q   <= 1'b0;
            exp_q    <= 5'(EXP_DEFAULT);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hits_q   <= hits_d;
            level_q  <= level_d;
            misses_q <= misses_d;
            tick_q   <= tick_d;
            exp_q    <= exp_c;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.level   = level_q;
    assign bus.misses  = misses_q;
    assign bus.state   = state_q;
    assign bus.exp_out = exp_q;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a
// cycle-level behavioural model of the scheduler rules.
module tb_game_tick_scheduler;
    localparam int CNT_W = 10, EXP_MIN = 2, EXP_DEFAULT = 3;
    localparam int HPL = 2, MAX_LEVEL = 6, MAX_MISSES = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_tick_scheduler_if bus();

    game_tick_scheduler #(
        .CNT_W(CNT_W), .EXP_MIN(EXP_MIN), .EXP_DEFAULT(EXP_DEFAULT),
        .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAX_LEVEL), .MAX_MISSES(MAX_MISSES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0, bad = 0;
    int m_state, m_cnt, m_level, m_hits, m_misses, m_tick, m_exp;

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic int ref_exp();
        if (bus.auto_mode) return EXP_MIN + 6 - m_level;
        for (int i = 6; i >= 0; i--)
            if (bus.speed_sw[i]) return EXP_MIN + 6 - i;
        return EXP_DEFAULT;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_level = 0; m_hits = 0;
        m_misses = 0; m_tick = 0; m_exp = EXP_DEFAULT;
    endtask

    // One clock edge of the reference: states 0 idle, 1 run, 2 paused, 3 over.
    task automatic model_edge();
        int e, period, n_state;
        e = ref_exp();
        period = 1 << e;
        n_state = m_state;
        m_tick = 0;
        if (m_state == 0 || m_state == 3) begin
            if (bus.start) begin
                n_state = 1; m_cnt = 0; m_level = 0; m_misses = 0; m_hits = 0;
            end
        end else if (m_state == 1) begin
            if (bus.hit) begin
                m_hits++;
                if (m_hits == HPL) begin
                    m_hits = 0;
                    if (bus.auto_mode && m_level < MAX_LEVEL) m_level++;
                end
            end
            if (bus.miss) m_misses++;
            if (bus.miss && m_misses == MAX_MISSES) n_state = 3;
            else if (bus.pause) n_state = 2;
            else if (m_cnt + 1 >= period) begin m_cnt = 0; m_tick = 1; end
            else m_cnt++;
        end else begin
            if (!bus.pause) n_state = 1;
        end
        m_state = n_state;
        m_exp = e;
    endtask

    task automatic check_all();
        chk("state", int'(bus.state), m_state);
        chk("tick", int'(bus.tick), m_tick);
        chk("level", int'(bus.level), m_level);
        chk("misses", int'(bus.misses), m_misses);
        chk("exp_out", int'(bus.exp_out), m_exp);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_start();
        bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic do_hit(input logic also_miss);
        bus.hit = 1'b1; bus.miss = also_miss; step();
        bus.hit = 1'b0; bus.miss = 1'b0; step();
    endtask

    task automatic do_miss();
        bus.miss = 1'b1; step(); bus.miss = 1'b0; step();
    endtask

    initial begin
        int n;
        bit found;
        reset = 1'b0;
        bus.start = 0; bus.pause = 0; bus.auto_mode = 0;
        bus.speed_sw = '0; bus.hit = 0; bus.miss = 0;
        model_reset();
        repeat (3) step();
        reset = 1'b1;
        step();

        // Asynchronous reset while running
        do_start();
        repeat (5) step();
        do_miss();
        #3 reset = 1'b0;
        #1 model_reset();
        chk("arst_state", int'(bus.state), 0);
        chk("arst_tick", int'(bus.tick), 0);
        chk("arst_misses", int'(bus.misses), 0);
        chk("arst_level", int'(bus.level), 0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // First tick lands 8 edges after the start edge, then every 8
        do_start();
        chk("t1_run", int'(bus.state), 1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("t1_tick_at", int'(bus.tick), (i == 8 || i == 16) ? 1 : 0);
        end
        chk("t1_exp", int'(bus.exp_out), 3);

        // Manual speeds: top switch wins, then slowest single switch
        bus.speed_sw = 7'b1000001;
        step();
        n = 0;
        for (int i = 0; i < 12; i++) begin step(); n += int'(bus.tick); end
        chk("t2_exp_fast", int'(bus.exp_out), 2);
        chk("t2_ticks_p4", n, 3);
        bus.speed_sw = 7'b0000001;
        step();
        chk("t2_exp_slow", int'(bus.exp_out), 8);
        n = 0;
        for (int i = 0; i < 512; i++) begin step(); n += int'(bus.tick); end
        chk("t2_ticks_p256", n, 2);

        // Shorten period while counter is past the new limit
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_cnt == 100) found = 1; else step();
        end
        chk("t6_reach_100", int'(found), 1);
        bus.speed_sw = 7'b1000001;
        step();
        chk("t6_tick_now", int'(bus.tick), 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin step(); n += int'(bus.tick); end
        chk("t6_ticks_p4", n, 2);

        // Pause at counter=5 with period 8
        bus.speed_sw = '0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_cnt == 5 && m_state == 1) found = 1; else step();
        end
        chk("t4_reach_5", int'(found), 1);
        bus.pause = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin step(); n += int'(bus.tick); end
        chk("t4_paused", int'(bus.state), 2);
        chk("t4_no_ticks", n, 0);
        bus.pause = 1'b0;
        n = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(); n++;
            if (bus.tick) found = 1;
        end
        chk("t4_resume_edges", n, 4);

        // Run out of misses, restart in auto mode
        do_miss(); do_miss(); do_miss();
        chk("t5a_over", int'(bus.state), 3);
        bus.auto_mode = 1'b1;
        do_start();
        chk("t5a_restart_misses", int'(bus.misses), 0);

        // Auto ramp: 2 hits per level, saturating at 6
        for (int i = 0; i < 4; i++) do_hit(1'b0);
        chk("t3_level2", int'(bus.level), 2);
        chk("t3_exp6", int'(bus.exp_out), 6);
        for (int i = 0; i < 20; i++) do_hit(1'b0);
        chk("t3_level_sat", int'(bus.level), 6);
        chk("t3_exp2", int'(bus.exp_out), 2);

        // Game over with a coincident hit; level held for display
        do_miss();
        do_hit(1'b1);
        bus.miss = 1'b1; step(); bus.miss = 1'b0;
        chk("t5_misses", int'(bus.misses), 3);
        chk("t5_over", int'(bus.state), 3);
        n = 0;
        for (int i = 0; i < 20; i++) begin step(); n += int'(bus.tick); end
        chk("t5_no_ticks", n, 0);
        chk("t5_level_held", int'(bus.level), 6);
        do_start();
        chk("t5_run", int'(bus.state), 1);
        chk("t5_clr_misses", int'(bus.misses), 0);
        chk("t5_clr_level", int'(bus.level), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            bus.start = ($urandom_range(0, 39) == 0);
            bus.hit   = !bus.pause && ($urandom_range(0, 3) == 0);
            bus.miss  = !bus.pause && ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) bus.auto_mode = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bus.speed_sw = 7'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Sequences the arrow-scroll datapath. Produces a one-cycle game-tick enable at a programmable period, replacing the raw divided-clock tap that currently selects game speed.
- Supports manual speed (switch priority encoding) and auto-ramp speed (level rises with hits).
- Owns the run, pause and game-over sequencing; gamePlay logic advances only on tick.
- Sits on the fast system clock beside gamePlay.

Parameters:
- CNT_W, 26, period counter width; must be >= EXP_MIN+7.
- EXP_MIN, 19, period exponent for fastest speed (speed_sw[6]).
- EXP_DEFAULT, 22, exponent when manual mode and no speed switch set.
- HITS_PER_LEVEL, 8, hits needed per auto level step (>= 1).
- MAX_LEVEL, 6, auto level saturation value (<= 6).
- MAX_MISSES, 10, misses that end the game (1..15).

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER.
- pause  in  1  level; holds play while high.
- auto_mode  in  1  1 = auto-ramp speed, 0 = manual switch speed.
- speed_sw  in  7  manual speed switches; highest index has priority.
- hit  in  1  one-cycle pulse per correct key hit.
- miss  in  1  one-cycle pulse per missed arrow.
- tick  out  1  registered one-cycle game-advance enable.
- level  out  3  current auto level, 0..MAX_LEVEL.
- misses  out  4  miss count, 0..MAX_MISSES.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER.
- exp_out  out  5  period exponent in use this cycle.

Behaviour:
- Reset values (reset low, async): state=IDLE, tick=0, level=0, misses=0, hit counter=0, period counter=0, exp_out=EXP_DEFAULT. Held while reset low; normal operation resumes on the first edge after release.
- Exponent is combinational, registered into exp_out:
  - Auto mode: EXP_MIN+6-level.
  - Manual mode: EXP_MIN+(6-i), where i is the highest set bit of speed_sw. EXP_DEFAULT if no bit is set.
  - period = 1<<exp.
- IDLE: no ticks; counters held. start -> RUN and clears period counter, level, misses, hit counter.
- RUN:
  - Period counter increments each cycle.
  - When counter >= period-1: counter<=0 and tick<=1 on that edge; tick is high for exactly the following cycle.
  - First tick occurs period edges after the edge that samples start.
  - Speed change mid-count: if counter already >= new period-1, tick on the next edge, then wrap.
- RUN with pause=1 -> PAUSED on that edge. No tick that cycle; counter frozen.
- PAUSED: counter, level, misses frozen; hit and miss ignored. pause=0 -> RUN; counting resumes from the frozen value.
- hit (RUN only):
  - Hit counter increments. At HITS_PER_LEVEL-1 it wraps to 0 and level increments, saturating at MAX_LEVEL.
  - The hit counter wraps even when level is saturated.
  - Level changes only in auto mode; manual mode still counts hits.
- miss (RUN only): misses increments. The edge where misses reaches MAX_MISSES moves state to OVER; any tick due on that edge is suppressed.
- hit and miss in the same cycle: both are processed.
- OVER: no ticks; level and misses held for display. start -> RUN with full clear.
- start while in RUN or PAUSED is ignored.
- Simultaneous start and pause in IDLE: enter RUN; PAUSED on the next edge if pause is still high.
- Counter arithmetic is unsigned CNT_W; no overflow possible given the CNT_W constraint.

Test Plan:
Bench parameters: CNT_W=10, EXP_MIN=2, EXP_DEFAULT=3, HITS_PER_LEVEL=2, MAX_LEVEL=6, MAX_MISSES=3.
1. Reset low mid-RUN -> state=00, tick=0, misses=0, level=0 immediately (async). After release, start pulse -> state=01; manual mode with speed_sw=0 gives exp_out=3 and ticks every 8 cycles, first tick 8 edges after start.
2. Manual mode, speed_sw=7'b1000001 -> exp_out=2, tick period 4. Then speed_sw=7'b0000001 -> exp_out=8, period 256.
3. auto_mode=1, start, then 4 hit pulses -> level=2, exp_out=6. 20 more hits -> level saturates at 6, exp_out=2.
4. pause high for 50 cycles mid-count at counter=5 -> state=10, no ticks, counter stays 5. pause low -> next tick after remaining cycles only.
5. Three miss pulses (one coincident with a hit) -> misses=3, state=11, no further ticks. start -> state=01, misses=0, level=0.
6. Speed shortened from period 256 to 4 while counter=100 -> tick on next edge, then period 4.
